// File: rtl/frame_window_sequencer_if.sv
// Handshake and status bundle between the frame sequencer and its source/sink.
// master = pixel source / controller side, slave = frame_window_sequencer.
interface frame_window_sequencer_if #(
  parameter int CW = 8
);
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          lb_shift;
  logic          win_valid;
  logic [CW-1:0] cen_row;
  logic [CW-1:0] cen_col;
  logic          busy;
  logic          frame_done;
  logic [15:0]   stall_cnt;

  modport master (
    output start, abort, in_valid, out_ready,
    input  in_ready, lb_shift, win_valid, cen_row, cen_col, busy, frame_done, stall_cnt
  );

  modport slave (
    input  start, abort, in_valid, out_ready,
    output in_ready, lb_shift, win_valid, cen_row, cen_col, busy, frame_done, stall_cnt
  );
endinterface

// File: rtl/frame_window_sequencer.sv
// Raster-order frame sequencer for the KxK window filter: pixel handshake, row/col
// tracking, window strobe, pipeline drain. Optional stall counter under STALL_COUNT_EN.
//
// state | meaning
// IDLE  | waiting for start
// PRIME | accepting pixels, first full window not yet seen
// RUN   | accepting pixels, windows being produced
// DRAIN | input closed, waiting PIPE_LAT cycles for the filter pipeline
module frame_window_sequencer #(
  parameter int IMG_W    = 130,
  parameter int IMG_H    = 130,
  parameter int K        = 3,
  parameter int PIPE_LAT = 4,
  parameter int CW       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  frame_window_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

  localparam int            DW         = $clog2(PIPE_LAT + 1);
  localparam logic [CW-1:0] W_LAST     = CW'(IMG_W - 1);
  localparam logic [CW-1:0] H_LAST     = CW'(IMG_H - 1);
  localparam logic [CW-1:0] K_LAST     = CW'(K - 1);
  localparam logic [CW-1:0] HALF       = CW'((K - 1) / 2);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_LAT);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
  localparam logic [DW-1:0] DRAIN_TWO  = DW'(2);

  state_t        state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] drain_cnt;
  logic          frame_done_q;
  logic          accepting;
  logic          accept;
  logic          col_last;
  logic          row_last;

  assign accepting      = (state == PRIME) || (state == RUN);
  assign bus.in_ready   = accepting && bus.out_ready;
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.lb_shift   = accept;
  assign bus.win_valid  = accept && (row >= K_LAST) && (col >= K_LAST);
  assign bus.cen_row    = bus.win_valid ? (row - HALF) : '0;
  assign bus.cen_col    = bus.win_valid ? (col - HALF) : '0;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = frame_done_q;
  assign col_last       = (col == W_LAST);
  assign row_last       = (row == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      drain_cnt    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.abort) begin
        state     <= IDLE;
        row       <= '0;
        col       <= '0;
        drain_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state <= PRIME;
              row   <= '0;
              col   <= '0;
            end
          end
          PRIME, RUN: begin
            if (accept) begin
              if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              if (state == PRIME && row == K_LAST && col == K_LAST)
                state <= RUN;
              if (state == RUN && row_last && col_last) begin
                state        <= DRAIN;
                drain_cnt    <= DRAIN_LOAD;
                // a one-deep pipeline finishes on the very next cycle
                frame_done_q <= (PIPE_LAT == 1);
              end
            end
          end
          DRAIN: begin
            drain_cnt <= drain_cnt - 1'b1;
            if (drain_cnt == DRAIN_TWO) frame_done_q <= 1'b1;
            if (drain_cnt == DRAIN_ONE) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state == IDLE && bus.start && !bus.abort) begin
      stall_q <= '0;
    end else if (accepting && bus.in_valid && !bus.in_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule
